// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter that shares one multi-cycle fpmul among N_REQ requesters.
// It issues one operation at a time and returns the product, or a watchdog abort, to the granted requester.
module fpmul_arbiter #(
   parameter int N_REQ       = 4,
   parameter int LOG_BIT     = 6,
   parameter int EXP_BIT     = 11,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*(2**LOG_BIT)-1:0] req_a,
   input  logic [N_REQ*(2**LOG_BIT)-1:0] req_b,
   output logic [N_REQ-1:0]        resp_valid,
   input  logic [N_REQ-1:0]        resp_ready,
   output logic [(2**LOG_BIT)-1:0] resp_data,
   output logic                    resp_err,
   output logic [(2**LOG_BIT)-1:0] fp_a,
   output logic [(2**LOG_BIT)-1:0] fp_b,
   output logic                    fp_start,
   input  logic [(2**LOG_BIT)-1:0] fp_out,
   input  logic                    fp_ready
);

   localparam int W  = 2**LOG_BIT;
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("fpmul_arbiter: N_REQ must be in 2..16");
   end
   if (EXP_BIT < 1 || EXP_BIT >= W - 1) begin : g_bad_exp
      $error("fpmul_arbiter: EXP_BIT does not fit the operand width");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("fpmul_arbiter: TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [GW-1:0]   last_grant;
   logic [CW-1:0]   wd_cnt;
   logic [GW-1:0]   scan_idx;
   logic [GW-1:0]   grant_idx;
   logic            grant_any;
   logic [N_REQ-1:0] grant_oh;

   // Scan starts one past the previous winner so every requester gets a turn.
   always_comb begin
      scan_idx  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      grant_oh  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = GW'((32'(last_grant) + 32'd1 + i) % 32'(N_REQ));
         if (!grant_any && req_valid[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (state == IDLE && !rst && grant_any)
         grant_oh[grant_idx] = 1'b1;
   end

   assign req_ready = grant_oh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GW'(N_REQ - 1);
         wd_cnt     <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         fp_a       <= '0;
         fp_b       <= '0;
         fp_start   <= 1'b0;
      end else begin
         fp_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_any) begin
                  fp_a       <= req_a[grant_idx*W +: W];
                  fp_b       <= req_b[grant_idx*W +: W];
                  last_grant <= grant_idx;
                  fp_start   <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               wd_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               // wd_cnt == 0 marks the first WAIT cycle, where fp_ready may be stale.
               if (wd_cnt != '0 && fp_ready) begin
                  resp_data  <= fp_out;
                  resp_err   <= 1'b0;
                  resp_valid <= N_REQ'(1) << last_grant;
                  state      <= RESP;
               end else if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  resp_data  <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= N_REQ'(1) << last_grant;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[last_grant]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
